fpu_addsub_issue: RTL and testbench

FPU_ADDSUB_ISSUE -- requirements
Module: fpu_addsub_issue

---
 rtl/fpu_addsub_issue_if.sv | 29 ++
 rtl/fpu_addsub_issue.sv | 78 +++++++
 tb/tb_fpu_addsub_issue.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_addsub_issue_if.sv
// Bundle of the issue-side, fadd-core and result-side signals of fpu_addsub_issue.
// slave is the issue block's view; master is the surrounding environment (requester, fadd unit, consumer).
interface fpu_addsub_issue_if #(
  parameter int TAG_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic              in_op;
  logic [31:0]       in_x1;
  logic [31:0]       in_x2;
  logic [TAG_W-1:0]  in_rd;
  logic [31:0]       core_x1;
  logic [31:0]       core_x2;
  logic [31:0]       core_y;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_y;
  logic [TAG_W-1:0]  out_rd;

  modport slave (
    input  in_valid, in_op, in_x1, in_x2, in_rd, core_y, out_ready,
    output in_ready, core_x1, core_x2, out_valid, out_y, out_rd
  );

  modport master (
    output in_valid, in_op, in_x1, in_x2, in_rd, core_y, out_ready,
    input  in_ready, core_x1, core_x2, out_valid, out_y, out_rd
  );
endinterface

// File: rtl/fpu_addsub_issue.sv
// Issue stage for a registered fadd core: operand registers, 2-stage tag pipe and
// credit-controlled in-order result FIFO so the core pipe never has to stall.
module fpu_addsub_issue #(
  parameter int TAG_W      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  fpu_addsub_issue_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  logic [31:0]      x1_q, x2_q;
  logic             s1_v, s2_v;
  logic [TAG_W-1:0] s1_rd, s2_rd;
  logic [31:0]      mem_y  [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_rd [FIFO_DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic [OW-1:0]    occ;
  logic             accept, push, pop, has_data;

  // Credits cover every op already issued, so a result always finds a free slot.
  always_comb begin
    occ      = OW'(count) + OW'(s1_v) + OW'(s2_v);
    has_data = (count != '0);
    push     = s2_v;
    pop      = has_data && bus.out_ready;
    accept   = bus.in_valid && bus.in_ready;
  end

  assign bus.in_ready  = (occ < OW'(FIFO_DEPTH));
  assign bus.core_x1   = x1_q;
  assign bus.core_x2   = x2_q;
  assign bus.out_valid = has_data;
  assign bus.out_y     = has_data ? mem_y[rptr]  : '0;
  assign bus.out_rd    = has_data ? mem_rd[rptr] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x1_q  <= '0;
      x2_q  <= '0;
      s1_v  <= 1'b0;
      s1_rd <= '0;
      s2_v  <= 1'b0;
      s2_rd <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        x1_q <= bus.in_x1;
        x2_q <= bus.in_op ? {~bus.in_x2[31], bus.in_x2[30:0]} : bus.in_x2;
      end
      s1_v  <= accept;
      s1_rd <= bus.in_rd;
      s2_v  <= s1_v;
      s2_rd <= s1_rd;
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: count gates visibility, so stale entries never escape.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_y[wptr]  <= bus.core_y;
      mem_rd[wptr] <= s2_rd;
    end
  end
endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Directed bench for fpu_addsub_issue with a behavioural fadd core and an in-order scoreboard.
module tb_fpu_addsub_issue;
  localparam int TAG_W = 6;

  typedef struct packed {
    logic [31:0]      y;
    logic [TAG_W-1:0] rd;
  } res_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic junk_mode = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   accepts = 0;
  int   pops = 0;
  int   cyc = 0;
  res_t sb[$];
  int   pop_cyc[$];

  always #5 clk = ~clk;

  fpu_addsub_issue_if #(.TAG_W(TAG_W)) bus ();

  fpu_addsub_issue #(.TAG_W(TAG_W), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  function automatic real s2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2s(s2r(a) + s2r(b));
  endfunction

  function automatic logic [31:0] itof(input int n);
    int          e;
    logic [31:0] m;
    if (n <= 0) return '0;
    e = 0;
    for (int i = 0; i < 24; i++) if (n[i]) e = i;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  // Downstream fadd unit: result registered one clock after its operands.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.core_y <= junk_mode ? 32'hDEAD_BEEF : fadd(bus.core_x1, bus.core_x2);
  end

  always @(negedge clk) begin
    res_t e;
    if (rstn) begin
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        pops++;
        pop_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          miscompares++;
          $error("FAIL unexpected_result observed y=%h rd=%0d expected none", bus.out_y, bus.out_rd);
        end else begin
          e = sb.pop_front();
          assert ({bus.out_y, bus.out_rd} === e) else begin
            miscompares++;
            $error("FAIL result observed y=%h rd=%0d expected y=%h rd=%0d",
                   bus.out_y, bus.out_rd, e.y, e.rd);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        accepts++;
        sb.push_back({fadd(bus.in_x1, bus.in_op ? {~bus.in_x2[31], bus.in_x2[30:0]} : bus.in_x2),
                      bus.in_rd});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] x1, input logic [31:0] x2, input logic op,
                       input logic [TAG_W-1:0] rd);
    bus.in_valid = 1'b1;
    bus.in_x1    = x1;
    bus.in_x2    = x2;
    bus.in_op    = op;
    bus.in_rd    = rd;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_sb_empty", 32'(sb.size()), 0);
  endtask

  initial begin
    int a0, p0, q0, dlt;
    bus.in_valid  = 1'b0;
    bus.in_op     = 1'b0;
    bus.in_x1     = '0;
    bus.in_x2     = '0;
    bus.in_rd     = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_core_x1", bus.core_x1, 0);
    chk("rst_core_x2", bus.core_x2, 0);
    chk("rst_out_y", bus.out_y, 0);
    chk("rst_out_rd", 32'(bus.out_rd), 0);
    @(negedge clk) rstn = 1'b1;
    tick();
    chk("rel_in_ready", 32'(bus.in_ready), 1);

    // Add 1.0 + 2.0, two-cycle latency
    drive(32'h3F80_0000, 32'h4000_0000, 1'b0, 6'd5);
    tick();
    bus.in_valid = 1'b0;
    chk("add_core_x1", bus.core_x1, 32'h3F80_0000);
    chk("add_core_x2", bus.core_x2, 32'h4000_0000);
    chk("add_lat0_valid", 32'(bus.out_valid), 0);
    tick();
    chk("add_lat1_valid", 32'(bus.out_valid), 0);
    tick();
    chk("add_lat2_valid", 32'(bus.out_valid), 1);
    chk("add_out_y", bus.out_y, 32'h4040_0000);
    chk("add_out_rd", 32'(bus.out_rd), 5);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("add_popped_valid", 32'(bus.out_valid), 0);
    chk("add_idle_out_y", bus.out_y, 0);

    // Subtract 3.0 - 1.0
    drive(32'h4040_0000, 32'h3F80_0000, 1'b1, 6'd9);
    tick();
    bus.in_valid = 1'b0;
    chk("sub_core_x2", bus.core_x2, 32'hBF80_0000);
    tick();
    tick();
    chk("sub_out_valid", 32'(bus.out_valid), 1);
    chk("sub_out_y", bus.out_y, 32'h4000_0000);
    chk("sub_out_rd", 32'(bus.out_rd), 9);
    bus.out_ready = 1'b1;
    tick();

    // Ignored inputs hold operands; popping an empty FIFO does nothing
    drive(32'h1234_5678, 32'h8765_4321, 1'b0, 6'd63);
    bus.in_valid = 1'b0;
    repeat (3) tick();
    bus.out_ready = 1'b0;
    chk("hold_core_x1", bus.core_x1, 32'h4040_0000);
    chk("hold_core_x2", bus.core_x2, 32'hBF80_0000);
    chk("hold_out_valid", 32'(bus.out_valid), 0);

    // Backpressure: six offers, four credits
    a0 = accepts;
    for (int i = 0; i < 6; i++) begin
      drive(itof(i + 1), itof(1), 1'b0, 6'(10 + i));
      tick();
    end
    bus.in_valid = 1'b0;
    chk("bp_accepts", 32'(accepts - a0), 4);
    chk("bp_in_ready_low", 32'(bus.in_ready), 0);
    tick();
    tick();
    chk("bp_in_ready_hold", 32'(bus.in_ready), 0);
    chk("bp_out_valid", 32'(bus.out_valid), 1);
    p0 = pops;
    bus.out_ready = 1'b1;
    wait_drain(20);
    chk("bp_pops", 32'(pops - p0), 4);
    chk("bp_in_ready_back", 32'(bus.in_ready), 1);
    chk("bp_empty", 32'(bus.out_valid), 0);

    // Throughput: 16 back-to-back with consumer always ready
    p0 = pops;
    q0 = pop_cyc.size();
    for (int i = 0; i < 16; i++) begin
      drive(itof(i + 2), itof(i % 3), 1'(i % 2), 6'(i));
      chk("thru_in_ready", 32'(bus.in_ready), 1);
      tick();
    end
    bus.in_valid = 1'b0;
    wait_drain(20);
    chk("thru_pops", 32'(pops - p0), 16);
    dlt = (pop_cyc.size() >= q0 + 16) ? pop_cyc[q0 + 15] - pop_cyc[q0] : -1;
    chk("thru_consecutive", 32'(dlt), 15);
    bus.out_ready = 1'b0;

    // Full FIFO: 3 buffered, 1 in s2, single pop cycle
    for (int i = 0; i < 4; i++) begin
      drive(itof(i + 4), itof(2), 1'b1, 6'(20 + i));
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("full_count_pre", 32'(dut.count), 3);
    chk("full_in_ready_pre", 32'(bus.in_ready), 0);
    p0 = pops;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("full_count_post", 32'(dut.count), 3);
    chk("full_one_pop", 32'(pops - p0), 1);
    chk("full_in_ready_post", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    wait_drain(20);
    bus.out_ready = 1'b0;

    // Reset with 2 in flight and 2 buffered; core_y carries garbage
    for (int i = 0; i < 4; i++) begin
      drive(itof(i + 1), itof(i + 1), 1'b0, 6'(30 + i));
      tick();
    end
    bus.in_valid = 1'b0;
    junk_mode = 1'b1;
    rstn = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    tick();
    tick();
    chk("mid_rst_hold_valid", 32'(bus.out_valid), 0);
    @(negedge clk) rstn = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_out_valid", 32'(bus.out_valid), 0);
    end
    junk_mode = 1'b0;
    p0 = pops;
    drive(itof(5), itof(3), 1'b1, 6'd40);
    tick();
    bus.in_valid = 1'b0;
    wait_drain(10);
    chk("post_rst_new_pop", 32'(pops - p0), 1);
    chk("post_rst_empty", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
